// File: rtl/si570_seq_pkg.sv
// Shared types, constants and the per-step I2C request table for the Si570
// frequency sequencer.
package si570_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_SETTLE,
    S_ERROR
  } state_e;

  localparam logic [2:0] STEP_MUX_SEL  = 3'd0;
  localparam logic [2:0] STEP_FREEZE   = 3'd1;
  localparam logic [2:0] STEP_WR_HI    = 3'd2;
  localparam logic [2:0] STEP_WR_LO    = 3'd3;
  localparam logic [2:0] STEP_UNFREEZE = 3'd4;
  localparam logic [2:0] STEP_NEWFREQ  = 3'd5;
  localparam logic [2:0] STEP_POLL     = 3'd6;

  localparam logic [7:0] REG_HS_N1      = 8'd7;
  localparam logic [7:0] REG_RFREQ_LO   = 8'd10;
  localparam logic [7:0] REG_CTRL       = 8'd135;
  localparam logic [7:0] REG_DCO_FREEZE = 8'd137;

  localparam logic [7:0] FREEZE_DCO_MASK = 8'h10;
  localparam logic [7:0] NEWFREQ_MASK    = 8'h40;

  localparam logic [3:0] ERR_POLL_TIMEOUT = 4'hF;

  typedef struct packed {
    logic [6:0]      addr;
    logic [3:0][7:0] wdata;
    logic [1:0]      bc_wr;
    logic [1:0]      bc_rd;
    logic            rd_wrn;
  } req_t;

  // cfg holds reg7 in [47:40] down to reg12 in [7:0].
  function automatic req_t step_request(input logic [2:0]  step,
                                        input logic [47:0] cfg,
                                        input logic [6:0]  mux_addr,
                                        input logic [7:0]  mux_mask,
                                        input logic [6:0]  si_addr);
    req_t r;
    r      = '0;
    r.addr = si_addr;
    case (step)
      STEP_MUX_SEL: begin
        r.addr     = mux_addr;
        r.wdata[0] = mux_mask;
      end
      STEP_FREEZE: begin
        r.wdata = {16'h0, FREEZE_DCO_MASK, REG_DCO_FREEZE};
        r.bc_wr = 2'd1;
      end
      STEP_WR_HI: begin
        r.wdata = {cfg[31:24], cfg[39:32], cfg[47:40], REG_HS_N1};
        r.bc_wr = 2'd3;
      end
      STEP_WR_LO: begin
        r.wdata = {cfg[7:0], cfg[15:8], cfg[23:16], REG_RFREQ_LO};
        r.bc_wr = 2'd3;
      end
      STEP_UNFREEZE: begin
        r.wdata = {24'h0, REG_DCO_FREEZE};
        r.bc_wr = 2'd1;
      end
      STEP_NEWFREQ: begin
        r.wdata = {16'h0, NEWFREQ_MASK, REG_CTRL};
        r.bc_wr = 2'd1;
      end
      STEP_POLL: begin
        r.wdata  = {24'h0, REG_CTRL};
        r.rd_wrn = 1'b1;
      end
      default: r.wdata = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/si570_freq_sequencer_if.sv
// Request (rv0) and response (rv1) channels between the sequencer and the
// i2c_master.
interface si570_freq_sequencer_if;
  logic            rv0_valid;
  logic            rv0_ready;
  logic [6:0]      rv0_slave_address;
  logic [3:0][7:0] rv0_wdata;
  logic [1:0]      rv0_burst_count_wr;
  logic [1:0]      rv0_burst_count_rd;
  logic            rv0_rd_wrn;
  logic            rv1_valid;
  logic            rv1_ready;
  logic [3:0][7:0] rv1_rdata;
  logic            rv1_nack;

  modport master (
    output rv0_valid, rv0_slave_address, rv0_wdata, rv0_burst_count_wr,
           rv0_burst_count_rd, rv0_rd_wrn, rv1_ready,
    input  rv0_ready, rv1_valid, rv1_rdata, rv1_nack
  );

  modport slave (
    input  rv0_valid, rv0_slave_address, rv0_wdata, rv0_burst_count_wr,
           rv0_burst_count_rd, rv0_rd_wrn, rv1_ready,
    output rv0_ready, rv1_valid, rv1_rdata, rv1_nack
  );
endinterface

// File: rtl/si570_freq_sequencer.sv
// Walks the Si570 reprogramming sequence through the PCA9548 mux using the
// i2c_master request/response channels, with NACK retry and NewFreq polling.
//
// state      | meaning
// S_IDLE     | waiting for i_start
// S_ISSUE    | request for current step presented on rv0
// S_WAIT_RSP | waiting for the i2c_master response on rv1
// S_SETTLE   | NewFreq cleared, counting down the settle time
// S_ERROR    | retries or polls exhausted, o_error held until next start
module si570_freq_sequencer
  import si570_seq_pkg::*;
#(
  parameter logic [6:0] MuxAddr      = 7'h74,
  parameter logic [7:0] MuxChanMask  = 8'h01,
  parameter logic [6:0] Si570Addr    = 7'h5D,
  parameter int         MaxRetries   = 2,
  parameter int         MaxPolls     = 16,
  parameter int         SettleCycles = 2500
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [47:0]             i_cfg,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [3:0]              o_err_step,
  si570_freq_sequencer_if.master  i2c
);

  localparam int RetryW  = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam int PollW   = (MaxPolls < 1) ? 1 : $clog2(MaxPolls + 1);
  localparam int SettleW = (SettleCycles < 2) ? 1 : $clog2(SettleCycles + 1);

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic [PollW-1:0]     poll_q, poll_d, poll_inc;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [47:0]          cfg_q, cfg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [3:0]           err_step_q, err_step_d;
  logic                 rv0_valid_q, rv0_valid_d;
  logic                 rv1_ready_q, rv1_ready_d;
  logic                 rv0_fire, rv1_fire;
  req_t                 req;

  assign req      = step_request(step_q, cfg_q, MuxAddr, MuxChanMask, Si570Addr);
  assign rv0_fire = rv0_valid_q & i2c.rv0_ready;
  assign rv1_fire = rv1_ready_q & i2c.rv1_valid;
  assign poll_inc = poll_q + PollW'(1);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    retry_d     = retry_q;
    poll_d      = poll_q;
    settle_d    = settle_q;
    cfg_d       = cfg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_step_d  = err_step_q;
    rv0_valid_d = rv0_valid_q;
    rv1_ready_d = rv1_ready_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (i_start) begin
          cfg_d       = i_cfg;
          error_d     = 1'b0;
          err_step_d  = 4'h0;
          step_d      = STEP_MUX_SEL;
          retry_d     = '0;
          poll_d      = '0;
          busy_d      = 1'b1;
          rv0_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rv0_fire) begin
          rv0_valid_d = 1'b0;
          rv1_ready_d = 1'b1;
          state_d     = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (rv1_fire) begin
          rv1_ready_d = 1'b0;
          // Every branch except the terminal ones re-enters ISSUE.
          rv0_valid_d = 1'b1;
          state_d     = S_ISSUE;
          if (i2c.rv1_nack) begin
            if (retry_q < RetryW'(MaxRetries)) begin
              retry_d = retry_q + RetryW'(1);
            end else begin
              rv0_valid_d = 1'b0;
              busy_d      = 1'b0;
              error_d     = 1'b1;
              err_step_d  = {1'b0, step_q};
              state_d     = S_ERROR;
            end
          end else if (step_q != STEP_POLL) begin
            step_d  = step_q + 3'd1;
            retry_d = '0;
          end else if ((i2c.rv1_rdata[0] & NEWFREQ_MASK) == 8'h00) begin
            rv0_valid_d = 1'b0;
            settle_d    = SettleW'(SettleCycles - 1);
            state_d     = S_SETTLE;
          end else if (poll_inc == PollW'(MaxPolls)) begin
            poll_d      = poll_inc;
            rv0_valid_d = 1'b0;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_step_d  = ERR_POLL_TIMEOUT;
            state_d     = S_ERROR;
          end else begin
            poll_d  = poll_inc;
            retry_d = '0;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - SettleW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      retry_q     <= '0;
      poll_q      <= '0;
      settle_q    <= '0;
      cfg_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_step_q  <= 4'h0;
      rv0_valid_q <= 1'b0;
      rv1_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      poll_q      <= poll_d;
      settle_q    <= settle_d;
      cfg_q       <= cfg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_step_q  <= err_step_d;
      rv0_valid_q <= rv0_valid_d;
      rv1_ready_q <= rv1_ready_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_err_step = err_step_q;

  // Request fields read zero whenever no request is presented.
  assign i2c.rv0_valid          = rv0_valid_q;
  assign i2c.rv0_slave_address  = rv0_valid_q ? req.addr   : '0;
  assign i2c.rv0_wdata          = rv0_valid_q ? req.wdata  : '0;
  assign i2c.rv0_burst_count_wr = rv0_valid_q ? req.bc_wr  : '0;
  assign i2c.rv0_burst_count_rd = rv0_valid_q ? req.bc_rd  : '0;
  assign i2c.rv0_rd_wrn         = rv0_valid_q ? req.rd_wrn : 1'b0;
  assign i2c.rv1_ready          = rv1_ready_q;

endmodule
